cpu_datapath_seq: RTL and testbench

Parametrised, sequenced successor to the single-cycle microcoded CPU datapath. It accepts one microinstruction per valid/ready handshake and executes it over an EXEC phase and an optional MEM phase: B-bus select, ALU, shifter, C-bus register writes and N/Z flags. Memory traffic uses a request/acknowledge handshake with a bounded wait, replacing the previous always-ready RAM. It sits between the microsequencer, which supplies `mir`, and the memory subsystem.

---
 rtl/cpu_datapath_seq.sv | 175 +++++++++++++++++
 tb/tb_cpu_datapath_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath_seq.sv
// Sequenced microcoded datapath: EXEC (B-bus, ALU, shifter, C-bus writes, N/Z) then optional MEM_W/MEM_R; debug taps built only with CPU_DEBUG_TAP_EN.
// Latency: 2 cycles per ALU-only op; each memory transaction adds 1 + wait cycles, bounded by TIMEOUT_CYC.
// Backpressure: mir_ready only in IDLE; memory phases stall on mem_ack until ack or timeout.
module cpu_datapath_seq #(
  parameter int DATA_W      = 32,
  parameter int NREGS       = 16,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 15,
  localparam int BSEL_W     = $clog2(NREGS),
  localparam int MIR_W      = 2 + 3 + 2 + NREGS + BSEL_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [MIR_W-1:0]  mir,
  input  logic              mir_valid,
  output logic              mir_ready,
  output logic              busy,
  output logic              flag_n,
  output logic              flag_z,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] on_c,
  output logic [DATA_W-1:0] on_b,
  output logic [DATA_W-1:0] on_ram_read,
  output logic [DATA_W-1:0] on_ram_write
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MEM_W, MEM_R} state_t;

  state_t              state_q, state_d;
  logic [MIR_W-1:0]    mir_q;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [CNT_W-1:0]    cnt_q;

  logic [1:0]          f_shift;
  logic [2:0]          f_alu;
  logic [1:0]          f_mem;
  logic [NREGS-1:0]    f_cwr;
  logic [BSEL_W-1:0]   f_bsel;

  logic [DATA_W-1:0]   a_bus, b_bus, alu_out, c_bus;
  logic                in_mem, tmo_hit, tmo_fire;

  assign f_shift = mir_q[MIR_W-1 -: 2];
  assign f_alu   = mir_q[MIR_W-3 -: 3];
  assign f_mem   = mir_q[MIR_W-6 -: 2];
  assign f_cwr   = mir_q[BSEL_W +: NREGS];
  assign f_bsel  = mir_q[BSEL_W-1:0];

  assign a_bus = regs[0];

  // Select codes past the register file read as zero.
  always_comb begin
    b_bus = '0;
    if (int'(f_bsel) < NREGS) b_bus = regs[f_bsel];
  end

  always_comb begin
    alu_out = '0;
    case (f_alu)
      3'd0: alu_out = a_bus;
      3'd1: alu_out = b_bus;
      3'd2: alu_out = a_bus + b_bus;
      3'd3: alu_out = a_bus + b_bus + DATA_W'(1);
      3'd4: alu_out = b_bus - a_bus;
      3'd5: alu_out = a_bus & b_bus;
      3'd6: alu_out = a_bus | b_bus;
      default: alu_out = b_bus + DATA_W'(1);
    endcase
  end

  always_comb begin
    c_bus = alu_out;
    case (f_shift)
      2'b01: c_bus = alu_out << 8;
      2'b10: c_bus = {alu_out[DATA_W-1], alu_out[DATA_W-1:1]};
      2'b11: c_bus = {1'b0, alu_out[DATA_W-1:1]};
      default: c_bus = alu_out;
    endcase
  end

  assign in_mem   = (state_q == MEM_W) || (state_q == MEM_R);
  assign tmo_hit  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign tmo_fire = in_mem && !mem_ack && tmo_hit;

  always_comb begin
    state_d   = state_q;
    mir_ready = (state_q == IDLE);
    case (state_q)
      IDLE: if (mir_valid) state_d = EXEC;
      EXEC: begin
        if (f_mem == 2'b00)  state_d = IDLE;
        else if (f_mem[1])   state_d = MEM_W;
        else                 state_d = MEM_R;
      end
      MEM_W: begin
        // A timed-out write abandons the pending read of an exchange.
        if (mem_ack)      state_d = f_mem[0] ? MEM_R : IDLE;
        else if (tmo_hit) state_d = IDLE;
      end
      MEM_R: if (mem_ack || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mir_q   <= '0;
      cnt_q   <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      bus_err <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      if (mir_ready && mir_valid) mir_q <= mir;
      if (in_mem && state_d == state_q) cnt_q <= cnt_q + CNT_W'(1);
      else                              cnt_q <= '0;
      if (state_q == EXEC) begin
        for (int i = 0; i < NREGS; i++) begin
          if (f_cwr[i]) regs[i] <= c_bus;
        end
        flag_z <= (c_bus == '0);
        flag_n <= c_bus[DATA_W-1];
      end
      if (state_q == MEM_R && mem_ack) regs[2] <= mem_rdata;
      if (tmo_fire) bus_err <= 1'b1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_req   = in_mem;
  assign mem_we    = (state_q == MEM_W);
  assign mem_addr  = regs[1][ADDR_W-1:0];
  assign mem_wdata = regs[2];

`ifdef CPU_DEBUG_TAP_EN
  logic [DATA_W-1:0] tap_c_q, tap_b_q, tap_rd_q, tap_wr_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tap_c_q  <= '0;
      tap_b_q  <= '0;
      tap_rd_q <= '0;
      tap_wr_q <= '0;
    end else begin
      if (state_q == EXEC) begin
        tap_c_q <= c_bus;
        tap_b_q <= b_bus;
      end
      if (state_q == MEM_R && mem_ack) tap_rd_q <= mem_rdata;
      tap_wr_q <= regs[2];
    end
  end

  assign on_c         = tap_c_q;
  assign on_b         = tap_b_q;
  assign on_ram_read  = tap_rd_q;
  assign on_ram_write = tap_wr_q;
`else
  assign on_c         = '0;
  assign on_b         = '0;
  assign on_ram_read  = '0;
  assign on_ram_write = '0;
`endif

endmodule

// File: tb/tb_cpu_datapath_seq.sv
// Bench for cpu_datapath_seq: transaction-level reference model, per-cycle compare, directed and random microinstructions.
module tb_cpu_datapath_seq;

  localparam int TO = 15;

  logic        clock, reset_n;
  logic [26:0] mir;
  logic        mir_valid, mir_ready, busy, flag_n, flag_z, bus_err;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, on_c, on_b, on_ram_read, on_ram_write;

  cpu_datapath_seq dut (
    .clock(clock), .reset_n(reset_n), .mir(mir), .mir_valid(mir_valid), .mir_ready(mir_ready),
    .busy(busy), .flag_n(flag_n), .flag_z(flag_z), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .on_c(on_c), .on_b(on_b), .on_ram_read(on_ram_read),
    .on_ram_write(on_ram_write)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [16];
  logic        m_n, m_z, m_err;
  logic [31:0] m_on_c;
  logic        exp_ready, exp_busy, exp_req, exp_we;
  logic        chk_en = 1'b0;
  int          req_cnt;
  logic [31:0] cap_addr, cap_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op, input logic [1:0] sh);
    logic [31:0] r;
    case (op)
      3'd0: r = a;
      3'd1: r = b;
      3'd2: r = a + b;
      3'd3: r = a + b + 32'd1;
      3'd4: r = b - a;
      3'd5: r = a & b;
      3'd6: r = a | b;
      default: r = b + 32'd1;
    endcase
    case (sh)
      2'b01: r = r * 32'd256;
      2'b10: r = (r >> 1) | (r & 32'h8000_0000);
      2'b11: r = r / 32'd2;
      default: ;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_n = 0; m_z = 0; m_err = 0; m_on_c = '0;
    exp_ready = 1; exp_busy = 0; exp_req = 0; exp_we = 0;
  endtask

  task automatic model_exec(input logic [1:0] sh, input logic [2:0] op,
                            input logic [15:0] cwr, input logic [3:0] bsel);
    logic [31:0] c;
    c = calc(m_regs[0], m_regs[bsel], op, sh);
    for (int i = 0; i < 16; i++) if (cwr[i]) m_regs[i] = c;
    m_z = (c == 0);
    m_n = c[31];
    m_on_c = c;
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("mir_ready", mir_ready, exp_ready);
      chk("busy", busy, exp_busy);
      chk("mem_req", mem_req, exp_req);
      if (exp_req) chk("mem_we", mem_we, exp_we);
      chk("mem_addr", mem_addr, m_regs[1][7:0]);
      chk("mem_wdata", mem_wdata, m_regs[2]);
      chk("flag_n", flag_n, m_n);
      chk("flag_z", flag_z, m_z);
      chk("bus_err", bus_err, m_err);
`ifdef CPU_DEBUG_TAP_EN
      chk("on_c", on_c, m_on_c);
`else
      chk("taps_zero", on_c | on_b | on_ram_read | on_ram_write, 32'h0);
`endif
      if (mem_req) req_cnt++;
      if (mem_req && mem_we && mem_ack) begin
        cap_addr  = {24'h0, mem_addr};
        cap_wdata = mem_wdata;
      end
    end
  end

  // One memory transaction; w < 0 means the responder never acks.
  task automatic mem_phase(input logic we, input int w, input logic [31:0] rval,
                           inout int ncyc, output logic ok);
    exp_req = 1; exp_we = we;
    ok = 0;
    for (int c = 0; c < TO; c++) begin
      mir_valid = $urandom_range(0, 1);
      mir = 27'($urandom);
      if (c == w) begin
        mem_ack = 1; mem_rdata = rval;
      end else begin
        mem_ack = 0; mem_rdata = $urandom;
      end
      @(posedge clock); #1;
      ncyc++;
      if (c == w) begin
        if (!we) m_regs[2] = rval;
        mem_ack = 0;
        ok = 1;
        break;
      end
    end
    if (!ok) m_err = 1;
  endtask

  task automatic run_instr(input logic [1:0] sh, input logic [2:0] op, input logic [1:0] mop,
                           input logic [15:0] cwr, input logic [3:0] bsel,
                           input int ww, input int wr, input logic [31:0] rval, output int ncyc);
    logic ok;
    mir = {sh, op, mop, cwr, bsel};
    mir_valid = 1;
    mem_ack = $urandom_range(0, 1);
    @(posedge clock); #1;
    ncyc = 1;
    mir_valid = $urandom_range(0, 1);
    mir = 27'($urandom);
    mem_ack = $urandom_range(0, 1);
    exp_ready = 0; exp_busy = 1; exp_req = 0;
    @(posedge clock); #1;
    ncyc++;
    model_exec(sh, op, cwr, bsel);
    mem_ack = 0;
    ok = 1;
    if (mop[1]) mem_phase(1'b1, ww, 32'h0, ncyc, ok);
    if (ok && mop[0]) mem_phase(1'b0, wr, rval, ncyc, ok);
    exp_req = 0; exp_we = 0; exp_ready = 1; exp_busy = 0;
    mir_valid = 0;
  endtask

  task automatic load_const(input int r, input logic [31:0] v);
    int n;
    run_instr(2'b00, 3'd0, 2'b01, 16'h0, 4'd0, 0, 0, v, n);
    if (r != 2) run_instr(2'b00, 3'd1, 2'b00, 16'(1 << r), 4'd2, 0, 0, 0, n);
  endtask

  function automatic int pick_wait();
    int p;
    p = $urandom_range(0, 15);
    if (p == 0) return -1;
    if (p == 1) return TO - 1;
    if (p == 2) return TO;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 0; mir = '0; mir_valid = 0; mem_ack = 0; mem_rdata = '0; req_cnt = 0;
    cap_addr = '0; cap_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    chk_en = 1;
    reset_n = 1;
    @(posedge clock); #1;

    // B+1 of reg3 (0) into reg3.
    run_instr(2'b00, 3'd7, 2'b00, 16'h0008, 4'd3, 0, 0, 0, n);
    chk("t1_cycles", n, 2);
    chk("t1_flag_z", flag_z, 1'b0);
    run_instr(2'b00, 3'd1, 2'b00, 16'h0004, 4'd3, 0, 0, 0, n);
    chk("t1_reg3", mem_wdata, 32'h1);

    // B-A with H=5, reg4=3.
    load_const(0, 32'd5);
    load_const(4, 32'd3);
    run_instr(2'b00, 3'd4, 2'b00, 16'h0024, 4'd4, 0, 0, 0, n);
    chk("t2_sub", mem_wdata, 32'hFFFF_FFFE);
    chk("t2_flag_n", flag_n, 1'b1);
    run_instr(2'b10, 3'd4, 2'b00, 16'h0004, 4'd4, 0, 0, 0, n);
    chk("t2_sra", mem_wdata, 32'hFFFF_FFFF);

    // Write with three wait cycles.
    load_const(1, 32'h12);
    load_const(2, 32'hCAFE);
    req_cnt = 0;
    run_instr(2'b00, 3'd0, 2'b10, 16'h0, 4'd0, 3, 0, 0, n);
    chk("t3_req_cycles", req_cnt, 4);
    chk("t3_addr", cap_addr, 32'h12);
    chk("t3_wdata", cap_wdata, 32'hCAFE);

    // Exchange, zero-wait.
    load_const(1, 32'h20);
    run_instr(2'b00, 3'd0, 2'b11, 16'h0, 4'd0, 0, 0, 32'hBEEF, n);
    chk("t4_cycles", n, 4);
    chk("t4_mdr", mem_wdata, 32'hBEEF);

    // Read that never gets acked.
    req_cnt = 0;
    run_instr(2'b00, 3'd0, 2'b01, 16'h0, 4'd0, 0, -1, 0, n);
    chk("t5_req_cycles", req_cnt, TO);
    chk("t5_bus_err", bus_err, 1'b1);
    chk("t5_mdr_kept", mem_wdata, 32'hBEEF);
    run_instr(2'b00, 3'd7, 2'b00, 16'h0040, 4'd6, 0, 0, 0, n);
    chk("t5_next_cycles", n, 2);

    // Reset while a read is waiting.
    mir = {2'b00, 3'd7, 2'b01, 16'h0080, 4'd0};
    mir_valid = 1;
    @(posedge clock); #1;
    mir_valid = 0;
    exp_ready = 0; exp_busy = 1;
    @(posedge clock); #1;
    model_exec(2'b00, 3'd7, 16'h0080, 4'd0);
    exp_req = 1; exp_we = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 0;
    @(posedge clock); #1;
    model_reset();
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_bus_err", bus_err, 1'b0);
    chk("t6_mdr", mem_wdata, 32'h0);
    chk("t6_mar", {24'h0, mem_addr}, 32'h0);
    reset_n = 1;
    @(posedge clock); #1;

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        mir_valid = 0;
        mem_ack = $urandom_range(0, 1);
        mem_rdata = $urandom;
        repeat ($urandom_range(1, 2)) @(posedge clock);
        #1;
        mem_ack = 0;
      end
      run_instr(2'($urandom), 3'($urandom), 2'($urandom), 16'($urandom & $urandom),
                4'($urandom), pick_wait(), pick_wait(), $urandom, n);
    end

    repeat (2) @(posedge clock);
    #1;
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
